// File: rtl/morra_cinese_cfg.sv
// ---------------------------------------------------------------------------
// morra_cinese_cfg
//
// Configurable rock-paper-scissors referee between two players. It evaluates
// one manche per clock, keeps the per-player win counts and decides when the
// game is over:
//   - by lead: at least MIN_MANCHE valid manche played and one player ahead
//     by LEAD or more wins, or
//   - by exhaustion: MAX_MANCHE valid manche played; the player with more wins
//     takes the game, otherwise it is a draw.
// Every output is registered. Inputs sampled at a rising edge are reflected on
// the outputs right after that same edge.
//
// Optional build macro:
//   MORRA_REPEAT_RULE_EN  When defined, the winner of the previous decisive
//                         manche may not replay the move it won with. Such a
//                         manche is invalid. When undefined, the last-winner
//                         memory does not exist, and only a 00 move makes a
//                         manche invalid.
//
// Parameters:
//   MIN_MANCHE  valid manche required before a lead can end the game
//   MAX_MANCHE  valid manche after which the game always ends
//   LEAD        win difference that ends the game once MIN_MANCHE is reached
//   CNT_W       counter width, 2**CNT_W > MAX_MANCHE
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset, overrides every other input
//   INIZIO      start / restart a game; moves in this cycle are ignored
//   PRIMO       player 1 move: 00 none, 01 rock, 10 paper, 11 scissors
//   SECONDO     player 2 move, same encoding
//   MANCHE      last manche: 00 invalid/none, 01 P1, 10 P2, 11 draw
//   PARTITA     game result: 00 in progress/none, 01 P1, 10 P2, 11 draw
//   NUM_MANCHE  valid manche played in the current game
// ---------------------------------------------------------------------------
module morra_cinese_cfg #(
    parameter int MIN_MANCHE = 4,
    parameter int MAX_MANCHE = 19,
    parameter int LEAD       = 2,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             INIZIO,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic [CNT_W-1:0] NUM_MANCHE
);

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;

    // Move encoding
    localparam logic [1:0] MV_NONE     = 2'b00;
    localparam logic [1:0] MV_ROCK     = 2'b01;
    localparam logic [1:0] MV_PAPER    = 2'b10;
    localparam logic [1:0] MV_SCISSORS = 2'b11;

    // Result encoding, shared by MANCHE and PARTITA
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_MANCHE);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_MANCHE);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W:0]   LEAD_C = (CNT_W+1)'(LEAD);

    logic [1:0]       state;
    logic [CNT_W-1:0] w1;
    logic [CNT_W-1:0] w2;

`ifdef MORRA_REPEAT_RULE_EN
    // Last-winner memory: a valid flag, the winner (0 = P1, 1 = P2) and the
    // winning move.
    logic       lw_valid;
    logic       lw_p2;
    logic [1:0] lw_move;
`endif

    logic                    moves_present;
    logic                    repeat_block;
    logic                    manche_valid;
    logic                    p1_beats;
    logic [1:0]              manche_res;
    logic [CNT_W-1:0]        num_next;
    logic [CNT_W-1:0]        w1_next;
    logic [CNT_W-1:0]        w2_next;
    logic signed [CNT_W:0]   diff;
    logic [CNT_W:0]          abs_diff;
    logic                    lead_reached;
    logic                    max_reached;
    logic                    game_over;
    logic [1:0]              final_res;

    // Evaluate the manche presented this cycle and the counter values that
    // would result from it. The sequential block commits these only in PLAY.
    always_comb begin
        moves_present = (PRIMO != MV_NONE) && (SECONDO != MV_NONE);

`ifdef MORRA_REPEAT_RULE_EN
        // Only the stored winner is restricted. The loser may play anything.
        repeat_block = lw_valid &&
                       (lw_p2 ? (SECONDO == lw_move) : (PRIMO == lw_move));
`else
        repeat_block = 1'b0;
`endif

        manche_valid = moves_present && !repeat_block;

        p1_beats = ((PRIMO == MV_ROCK)     && (SECONDO == MV_SCISSORS)) ||
                   ((PRIMO == MV_PAPER)    && (SECONDO == MV_ROCK))     ||
                   ((PRIMO == MV_SCISSORS) && (SECONDO == MV_PAPER));

        if (!manche_valid) begin
            manche_res = RES_NONE;
        end else if (PRIMO == SECONDO) begin
            manche_res = RES_DRAW;
        end else if (p1_beats) begin
            manche_res = RES_P1;
        end else begin
            manche_res = RES_P2;
        end

        num_next = NUM_MANCHE + ONE_C;
        w1_next  = (manche_res == RES_P1) ? (w1 + ONE_C) : w1;
        w2_next  = (manche_res == RES_P2) ? (w2 + ONE_C) : w2;

        // The counters are bounded by MAX_MANCHE, so one extra bit holds any
        // signed difference without overflow.
        diff = $signed({1'b0, w1_next}) - $signed({1'b0, w2_next});
        if (diff[CNT_W]) begin
            abs_diff = -diff;
        end else begin
            abs_diff = diff;
        end

        lead_reached = (num_next >= MIN_C) && (abs_diff >= LEAD_C);
        max_reached  = (num_next == MAX_C);
        game_over    = lead_reached || max_reached;

        // When the lead rule fires, LEAD >= 1 guarantees the counts differ.
        // So the same comparison gives the leader in both end cases.
        if (w1_next > w2_next) begin
            final_res = RES_P1;
        end else if (w2_next > w1_next) begin
            final_res = RES_P2;
        end else begin
            final_res = RES_DRAW;
        end
    end

    // Main controller. rst has priority over INIZIO, and INIZIO has priority
    // over whatever the current state would do with the moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            MANCHE     <= RES_NONE;
            PARTITA    <= RES_NONE;
            NUM_MANCHE <= '0;
            w1         <= '0;
            w2         <= '0;
`ifdef MORRA_REPEAT_RULE_EN
            lw_valid   <= 1'b0;
            lw_p2      <= 1'b0;
            lw_move    <= MV_NONE;
`endif
        end else if (INIZIO) begin
            state      <= ST_PLAY;
            MANCHE     <= RES_NONE;
            PARTITA    <= RES_NONE;
            NUM_MANCHE <= '0;
            w1         <= '0;
            w2         <= '0;
`ifdef MORRA_REPEAT_RULE_EN
            lw_valid   <= 1'b0;
            lw_p2      <= 1'b0;
            lw_move    <= MV_NONE;
`endif
        end else begin
            case (state)
                ST_PLAY: begin
                    MANCHE <= manche_res;
                    if (manche_valid) begin
                        NUM_MANCHE <= num_next;
                        w1         <= w1_next;
                        w2         <= w2_next;
`ifdef MORRA_REPEAT_RULE_EN
                        // A draw forgets the last winner. A decisive manche
                        // replaces it.
                        if (manche_res == RES_DRAW) begin
                            lw_valid <= 1'b0;
                        end else begin
                            lw_valid <= 1'b1;
                            lw_p2    <= (manche_res == RES_P2);
                            lw_move  <= (manche_res == RES_P2) ? SECONDO : PRIMO;
                        end
`endif
                        if (game_over) begin
                            PARTITA <= final_res;
                            state   <= ST_END;
                        end else begin
                            PARTITA <= RES_NONE;
                        end
                    end else begin
                        PARTITA <= RES_NONE;
                    end
                end

                ST_END: begin
                    // The final manche stays visible for one cycle only.
                    // PARTITA and NUM_MANCHE keep their values.
                    MANCHE <= RES_NONE;
                end

                default: begin
                    // IDLE, or an unused encoding: go back to a quiet IDLE.
                    state      <= ST_IDLE;
                    MANCHE     <= RES_NONE;
                    PARTITA    <= RES_NONE;
                    NUM_MANCHE <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morra_cinese_cfg.sv
// ---------------------------------------------------------------------------
// tb_morra_cinese_cfg
//
// Scoreboard bench for morra_cinese_cfg with default parameters. Every driven
// cycle advances a game-level reference model. The expected output triple is
// pushed into a queue, and a monitor pops it one time unit after the next
// rising edge and compares it with the DUT outputs. The model follows
// MORRA_REPEAT_RULE_EN the same way the DUT does.
// ---------------------------------------------------------------------------
module tb_morra_cinese_cfg;

    localparam int MIN_M = 4;
    localparam int MAX_M = 19;
    localparam int LEADV = 2;
    localparam int CW    = 5;

`ifdef MORRA_REPEAT_RULE_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]    manche;
        logic [1:0]    partita;
        logic [CW-1:0] num;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          INIZIO;
    logic [1:0]    PRIMO;
    logic [1:0]    SECONDO;
    logic [1:0]    MANCHE;
    logic [1:0]    PARTITA;
    logic [CW-1:0] NUM_MANCHE;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleNo    = 0;

    // Reference model state. mode: 0 idle, 1 playing, 2 game over.
    int         mMode;
    int         mN;
    int         mWins1;
    int         mWins2;
    bit         mLastValid;
    int         mLastWho;
    int         mLastMove;
    logic [1:0] mManche;
    logic [1:0] mPartita;

    morra_cinese_cfg #(
        .MIN_MANCHE(MIN_M),
        .MAX_MANCHE(MAX_M),
        .LEAD(LEADV),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .INIZIO(INIZIO),
        .PRIMO(PRIMO),
        .SECONDO(SECONDO),
        .MANCHE(MANCHE),
        .PARTITA(PARTITA),
        .NUM_MANCHE(NUM_MANCHE)
    );

    always #5 clk = ~clk;

    // Rock=1, paper=2, scissors=3: a beats b when a is one step ahead mod 3.
    function automatic bit beats(input int a, input int b);
        return (((a - b) + 3) % 3) == 1;
    endfunction

    task automatic modelStep(input bit r, input bit ini, input int p1, input int p2);
        bit valid;
        int d;
        if (r) begin
            mMode = 0; mN = 0; mWins1 = 0; mWins2 = 0; mLastValid = 0;
            mLastWho = 0; mLastMove = 0; mManche = 2'b00; mPartita = 2'b00;
        end else if (ini) begin
            mMode = 1; mN = 0; mWins1 = 0; mWins2 = 0; mLastValid = 0;
            mLastWho = 0; mLastMove = 0; mManche = 2'b00; mPartita = 2'b00;
        end else if (mMode == 1) begin
            valid = (p1 != 0) && (p2 != 0);
            if (REPEAT_ON && mLastValid &&
                ((mLastWho == 1 && p1 == mLastMove) || (mLastWho == 2 && p2 == mLastMove)))
                valid = 0;
            if (!valid) begin
                mManche = 2'b00;
                mPartita = 2'b00;
            end else begin
                mN++;
                if (p1 == p2) begin
                    mManche = 2'b11; mLastValid = 0;
                end else if (beats(p1, p2)) begin
                    mWins1++; mManche = 2'b01;
                    mLastValid = 1; mLastWho = 1; mLastMove = p1;
                end else begin
                    mWins2++; mManche = 2'b10;
                    mLastValid = 1; mLastWho = 2; mLastMove = p2;
                end
                d = mWins1 - mWins2;
                if ((mN >= MIN_M && (d >= LEADV || -d >= LEADV)) || mN == MAX_M) begin
                    mPartita = (d > 0) ? 2'b01 : (d < 0) ? 2'b10 : 2'b11;
                    mMode = 2;
                end else begin
                    mPartita = 2'b00;
                end
            end
        end else if (mMode == 2) begin
            mManche = 2'b00;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ini, input int p1, input int p2);
        exp_t e;
        @(negedge clk);
        rst = r; INIZIO = ini; PRIMO = 2'(p1); SECONDO = 2'(p2);
        modelStep(r, ini, p1, p2);
        e.manche = mManche;
        e.partita = mPartita;
        e.num = CW'(mN);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (MANCHE !== e.manche) begin
            mismatched++;
            $display("[TB] FAIL manche cycle %0d: got %b expected %b", cycleNo, MANCHE, e.manche);
        end
        compared++;
        if (PARTITA !== e.partita) begin
            mismatched++;
            $display("[TB] FAIL partita cycle %0d: got %b expected %b", cycleNo, PARTITA, e.partita);
        end
        compared++;
        if (NUM_MANCHE !== e.num) begin
            mismatched++;
            $display("[TB] FAIL num_manche cycle %0d: got %0d expected %0d", cycleNo, NUM_MANCHE, e.num);
        end
    endtask

    // Monitor: a fresh output triple appears after every edge that follows a
    // driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycleNo++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int p1;
        int p2;
        rst = 1'b1; INIZIO = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;

        // Reset, then the IDLE state ignores moves.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 3);

        // Start the game, a win, a repeat of the winning move, and a new move.
        applyStimulus(0, 1, 2, 2);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 2, 3);

        // Lead ending after four P1 wins, then the END hold.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 3);
        applyStimulus(0, 0, 2, 1);
        applyStimulus(0, 0, 3, 2);
        applyStimulus(0, 0, 1, 3);
        applyStimulus(0, 0, 2, 1);
        applyStimulus(0, 0, 3, 1);

        // Nineteen draws reach the manche limit.
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < MAX_M; i++) applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 3);
        applyStimulus(0, 0, 2, 1);

        // Restart mid-game, then rst together with INIZIO.
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3, 3);
        applyStimulus(0, 1, 1, 3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2, 2);
        applyStimulus(1, 1, 1, 3);
        applyStimulus(0, 0, 1, 3);

        // Repeated winning move, and a 00 move.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 3);

        // Random play with occasional restarts and resets.
        for (int i = 0; i < 3000; i++) begin
            p1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            p2 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, p1, p2);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
